// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the write-back source codes, the forwarding select codes, the
// scoreboard entry type and a helper that decides whether an entry
// produces a given architectural register.
package hazard_pkg;

  // Write-back source select (decode wb_sel).
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Execute operand select.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // x0 is hard-wired to zero, so a "write" to it never produces a value.
  function automatic logic sb_writes(sb_entry_t e, logic [4:0] r);
    return e.vld & e.wr & (e.rd == r) & (r != 5'd0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
// Ports:
//   i_clk    core clock
//   i_rst_n  asynchronous active-low reset, clears the count
//   inc      count one event this cycle
//   count    current value, holds at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Keeps a shadow scoreboard of the destinations in E, M and W and derives
// operand forwarding selects, load-use stalls and branch flushes from it.
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   RS1/RS2/RD_ADDR_D, RegWriteD,
//   ResultSrcD, insn_vldD        decode-stage instruction fields
//   RS1_ADDR_E, RS2_ADDR_E       source registers of the instruction in E
//   PCSrcE                       taken branch/jump resolved in E
//   StallF, StallD, FlushD,
//   FlushE                       pipeline register controls
//   ForwardAE, ForwardBE         execute operand selects
//   o_stall_cnt, o_flush_cnt     saturating event counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       RS1_ADDR_D,
  input  logic [4:0]       RS2_ADDR_D,
  input  logic [4:0]       RD_ADDR_D,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             insn_vldD,
  input  logic [4:0]       RS1_ADDR_E,
  input  logic [4:0]       RS2_ADDR_E,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  sb_entry_t r_sb_e, r_sb_m, r_sb_w;
  sb_entry_t w_sb_d;
  logic      w_lu;

  function automatic logic [1:0] fwd_sel(sb_entry_t m, sb_entry_t w, logic [4:0] rs);
    if (sb_writes(m, rs)) begin
      return FWD_M;
    end else if (sb_writes(w, rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    w_sb_d     = SB_BUBBLE;
    w_sb_d.vld = insn_vldD;
    w_sb_d.rd  = RD_ADDR_D;
    w_sb_d.wr  = RegWriteD;
    w_sb_d.ld  = (ResultSrcD == WB_MEM);
  end

  // Both rs fields are compared whatever the format; false stalls are harmless.
  assign w_lu = r_sb_e.vld & r_sb_e.ld & r_sb_e.wr & (r_sb_e.rd != 5'd0) &
                ((r_sb_e.rd == RS1_ADDR_D) | (r_sb_e.rd == RS2_ADDR_D));

  // A taken branch squashes the stalled instruction anyway, so flush wins.
  always_comb begin
    StallF    = w_lu & ~PCSrcE;
    StallD    = w_lu & ~PCSrcE;
    FlushD    = PCSrcE;
    FlushE    = w_lu | PCSrcE;
    ForwardAE = fwd_sel(r_sb_m, r_sb_w, RS1_ADDR_E);
    ForwardBE = fwd_sel(r_sb_m, r_sb_w, RS2_ADDR_E);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sb_e <= SB_BUBBLE;
      r_sb_m <= SB_BUBBLE;
      r_sb_w <= SB_BUBBLE;
    end else begin
      r_sb_w <= r_sb_m;
      r_sb_m <= r_sb_e;
      r_sb_e <= FlushE ? SB_BUBBLE : w_sb_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .inc    (StallD),
    .count  (o_stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .inc    (PCSrcE),
    .count  (o_flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based pipeline model. A second instance with 4-bit
// counters exercises saturation.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk, rst_n;
  logic [4:0] rs1d, rs2d, rdd, rs1e, rs2e;
  logic       regwr, vldd, pcsrc;
  logic [1:0] srcd;

  logic        stf, std, fld, fle;
  logic [1:0]  fae, fbe;
  logic [15:0] scnt, fcnt;
  logic        stf4, std4, fld4, fle4;
  logic [1:0]  fae4, fbe4;
  logic [3:0]  scnt4, fcnt4;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .RS1_ADDR_D(rs1d), .RS2_ADDR_D(rs2d), .RD_ADDR_D(rdd),
    .RegWriteD(regwr), .ResultSrcD(srcd), .insn_vldD(vldd), .RS1_ADDR_E(rs1e),
    .RS2_ADDR_E(rs2e), .PCSrcE(pcsrc), .StallF(stf), .StallD(std), .FlushD(fld),
    .FlushE(fle), .ForwardAE(fae), .ForwardBE(fbe), .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .RS1_ADDR_D(rs1d), .RS2_ADDR_D(rs2d), .RD_ADDR_D(rdd),
    .RegWriteD(regwr), .ResultSrcD(srcd), .insn_vldD(vldd), .RS1_ADDR_E(rs1e),
    .RS2_ADDR_E(rs2e), .PCSrcE(pcsrc), .StallF(stf4), .StallD(std4), .FlushD(fld4),
    .FlushE(fle4), .ForwardAE(fae4), .ForwardBE(fbe4), .o_stall_cnt(scnt4),
    .o_flush_cnt(fcnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // pipe[0] is the instruction in E, pipe[1] in M, pipe[2] in W.
  typedef struct packed {
    bit       vld;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } ent_t;

  ent_t pipe[$];
  int   m_stall, m_flush, m_stall4, m_flush4;

  task automatic model_reset();
    ent_t b;
    b = '0;
    pipe = {b, b, b};
    m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
  endtask

  function automatic bit produces(ent_t e, bit [4:0] r);
    return e.vld && e.wr && e.rd == r && r != 0;
  endfunction

  // Youngest producer beyond E wins; an instruction in E has no result yet.
  function automatic bit [1:0] exp_fwd(bit [4:0] r);
    if (produces(pipe[1], r)) return 2'b10;
    if (produces(pipe[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_lu();
    ent_t e;
    e = pipe[0];
    return e.vld && e.ld && e.wr && e.rd != 0 && (e.rd == rs1d || e.rd == rs2d);
  endfunction

  task automatic advance();
    ent_t n;
    bit   do_stall, do_flush_e;
    do_stall   = exp_lu() && !pcsrc;
    do_flush_e = exp_lu() || pcsrc;
    @(posedge clk);
    if (do_stall) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall4 < 15) m_stall4++;
    end
    if (pcsrc) begin
      if (m_flush < 65535) m_flush++;
      if (m_flush4 < 15) m_flush4++;
    end
    n = '0;
    if (!do_flush_e) begin
      n.vld = vldd; n.rd = rdd; n.wr = regwr; n.ld = (srcd == WB_MEM);
    end
    pipe.push_front(n);
    void'(pipe.pop_back());
    #1;
  endtask

  task automatic drive_d(input bit [4:0] a1, input bit [4:0] a2, input bit [4:0] d,
                         input bit w, input bit [1:0] s, input bit v);
    rs1d = a1; rs2d = a2; rdd = d; regwr = w; srcd = s; vldd = v;
  endtask

  task automatic drive_e(input bit [4:0] a1, input bit [4:0] a2, input bit p);
    rs1e = a1; rs2e = a2; pcsrc = p;
  endtask

  task automatic idle();
    drive_d(0, 0, 0, 0, WB_ALU, 0);
    drive_e(0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive_d(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 2'($urandom),
              1'($urandom));
      drive_e(5'($urandom), 5'($urandom), 1'($urandom));
      @(posedge clk); #2;
      total++; if (scnt !== 16'd0 || fcnt !== 16'd0) begin bad++;
        $display("FAIL reset_hold_cnt: stall=%0d flush=%0d want 0 0", scnt, fcnt); end
    end
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    total++; if ({stf, std, fld, fle} !== 4'b0000) begin bad++;
      $display("FAIL reset_ctrl: stf/std/fld/fle=%b want 0000", {stf, std, fld, fle}); end
    total++; if (fae !== 2'b00 || fbe !== 2'b00) begin bad++;
      $display("FAIL reset_fwd: A=%b B=%b want 00 00", fae, fbe); end
    total++; if (scnt !== 16'd0 || fcnt !== 16'd0 || scnt4 !== 4'd0 || fcnt4 !== 4'd0) begin
      bad++; $display("FAIL reset_cnt: %0d %0d %0d %0d want all 0", scnt, fcnt, scnt4, fcnt4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_chain();
    // add x5 ; sub x?,x5 -> forward from M
    idle(); drive_d(1, 2, 5, 1, WB_ALU, 1); advance();
    idle(); drive_d(5, 6, 8, 1, WB_ALU, 1); drive_e(1, 2, 0); advance();
    idle(); drive_e(5, 6, 0); #2;
    total++; if (fae !== 2'b10) begin bad++;
      $display("FAIL alu_fwd_m: ForwardAE=%b want 10", fae); end
    total++; if (fbe !== 2'b00) begin bad++;
      $display("FAIL alu_fwd_b_rf: ForwardBE=%b want 00", fbe); end
    advance(); advance(); advance();
    // add x5 ; nop ; sub x?,x5 -> forward from W
    idle(); drive_d(1, 2, 5, 1, WB_ALU, 1); advance();
    idle(); advance();
    idle(); drive_d(5, 6, 9, 1, WB_ALU, 1); advance();
    idle(); drive_e(5, 6, 0); #2;
    total++; if (fae !== 2'b01) begin bad++;
      $display("FAIL alu_fwd_w: ForwardAE=%b want 01", fae); end
    advance(); advance(); advance();
  endtask

  task automatic test_double_match();
    idle(); drive_d(0, 0, 7, 1, WB_ALU, 1); advance();
    idle(); drive_d(0, 0, 7, 1, WB_PC4, 1); advance();
    idle(); drive_d(0, 7, 0, 0, WB_ALU, 1); advance();
    idle(); drive_e(0, 7, 0); #2;
    total++; if (fbe !== 2'b10) begin bad++;
      $display("FAIL double_match: ForwardBE=%b want 10", fbe); end
    // x0 written with wr=1 must never forward
    idle(); drive_d(0, 0, 0, 1, WB_ALU, 1); advance();
    idle(); advance();
    idle(); drive_e(0, 0, 0); #2;
    total++; if (fae !== 2'b00 || fbe !== 2'b00) begin bad++;
      $display("FAIL x0_fwd: A=%b B=%b want 00 00", fae, fbe); end
    advance(); advance(); advance();
  endtask

  task automatic test_load_use();
    int s0;
    s0 = int'(scnt);
    idle(); drive_d(1, 0, 3, 1, WB_MEM, 1); advance();
    idle(); drive_d(1, 3, 10, 1, WB_ALU, 1); #2;
    total++; if ({stf, std, fle, fld} !== 4'b1110) begin bad++;
      $display("FAIL lu_stall: stf/std/fle/fld=%b want 1110", {stf, std, fle, fld}); end
    advance();
    #2;
    total++; if ({stf, std, fle} !== 3'b000) begin bad++;
      $display("FAIL lu_one_cycle: stf/std/fle=%b want 000", {stf, std, fle}); end
    advance();
    idle(); drive_e(1, 3, 0); #2;
    total++; if (fbe !== 2'b01) begin bad++;
      $display("FAIL lu_fwd_w: ForwardBE=%b want 01", fbe); end
    total++; if (int'(scnt) !== s0 + 1) begin bad++;
      $display("FAIL lu_cnt: stall_cnt=%0d want %0d", scnt, s0 + 1); end
    advance(); advance(); advance();
  endtask

  task automatic test_branch_vs_lu();
    int s0, f0;
    idle(); drive_d(0, 0, 4, 1, WB_MEM, 1); advance();
    drive_d(4, 0, 11, 1, WB_ALU, 1); drive_e(0, 0, 1); #2;
    total++; if ({stf, std, fld, fle} !== 4'b0011) begin bad++;
      $display("FAIL br_lu: stf/std/fld/fle=%b want 0011", {stf, std, fld, fle}); end
    s0 = int'(scnt); f0 = int'(fcnt);
    advance();
    idle(); #2;
    total++; if (int'(fcnt) !== f0 + 1 || int'(scnt) !== s0) begin bad++;
      $display("FAIL br_lu_cnt: flush=%0d stall=%0d want %0d %0d", fcnt, scnt, f0 + 1, s0);
    end
    total++; if ({fld, fle} !== 2'b00) begin bad++;
      $display("FAIL br_single: fld/fle=%b want 00", {fld, fle}); end
    advance(); advance(); advance();
  endtask

  task automatic test_saturation();
    idle();
    for (int i = 0; i < 20; i++) begin
      drive_e(0, 0, 1); advance();
    end
    idle(); #2;
    total++; if (fcnt4 !== 4'd15) begin bad++;
      $display("FAIL sat_flush4: flush_cnt=%0d want 15", fcnt4); end
    total++; if (int'(fcnt) !== m_flush) begin bad++;
      $display("FAIL sat_flush16: flush_cnt=%0d want %0d", fcnt, m_flush); end
    drive_e(0, 0, 1); advance(); idle(); #2;
    total++; if (fcnt4 !== 4'd15) begin bad++;
      $display("FAIL sat_hold: flush_cnt=%0d want 15", fcnt4); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_d(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 2)),
              1'($urandom_range(0, 4) != 0));
      drive_e(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 7) == 0));
      #2;
      total++; if (std !== (exp_lu() && !pcsrc) || stf !== std) begin bad++;
        $display("FAIL rnd_stall[%0d]: stf=%b std=%b want %b", i, stf, std,
                 exp_lu() && !pcsrc); end
      total++; if (fle !== (exp_lu() || pcsrc) || fld !== pcsrc) begin bad++;
        $display("FAIL rnd_flush[%0d]: fle=%b fld=%b want %b %b", i, fle, fld,
                 exp_lu() || pcsrc, pcsrc); end
      total++; if (fae !== exp_fwd(rs1e) || fbe !== exp_fwd(rs2e)) begin bad++;
        $display("FAIL rnd_fwd[%0d]: A=%b B=%b want %b %b", i, fae, fbe, exp_fwd(rs1e),
                 exp_fwd(rs2e)); end
      total++; if (int'(scnt) !== m_stall || int'(fcnt) !== m_flush ||
                   int'(scnt4) !== m_stall4 || int'(fcnt4) !== m_flush4) begin bad++;
        $display("FAIL rnd_cnt[%0d]: %0d %0d %0d %0d want %0d %0d %0d %0d", i, scnt, fcnt,
                 scnt4, fcnt4, m_stall, m_flush, m_stall4, m_flush4); end
      advance();
    end
  endtask

  task automatic test_async_reset();
    idle(); drive_d(0, 0, 2, 1, WB_MEM, 1); advance();
    drive_d(2, 0, 12, 1, WB_ALU, 1); drive_e(0, 0, 1); advance();
    idle(); drive_d(0, 0, 6, 1, WB_MEM, 1); advance();
    drive_d(6, 0, 0, 0, WB_ALU, 1); drive_e(0, 0, 0); #2;
    total++; if (std !== 1'b1) begin bad++;
      $display("FAIL arst_pre: StallD=%b want 1", std); end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if ({stf, std, fld, fle} !== 4'b0000) begin bad++;
      $display("FAIL arst_ctrl: stf/std/fld/fle=%b want 0000", {stf, std, fld, fle}); end
    total++; if (scnt !== 16'd0 || fcnt !== 16'd0) begin bad++;
      $display("FAIL arst_cnt: stall=%0d flush=%0d want 0 0", scnt, fcnt); end
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    total++; if (fae !== 2'b00 || fbe !== 2'b00 || fle !== 1'b0) begin bad++;
      $display("FAIL arst_after: A=%b B=%b fle=%b want 00 00 0", fae, fbe, fle); end
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_chain();
    test_double_match();
    test_load_use();
    test_branch_vs_lu();
    test_saturation();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
